l1_mem_arbiter: RTL and testbench
=================================

L1_MEM_ARBITER -- requirements
Module: l1_mem_arbiter

Interface
REQ-001 Parameter LINESIZE, default 8, words per cache-line burst (power of two, 2..16).
REQ-002 Parameter ADDRBITS, default 30, width of the downstream word address.
REQ-003 Port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 Port RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 Port I_REQ / I_ADDR  input  1 / 32  instruction-cache line-fill request and byte address.
REQ-006 Port I_DONE / I_DATA  output  1 / 32  per-word completion pulse and word to the instruction cache.
REQ-007 Port D_REQ / D_ADDR  input  1 / 32  data-cache line-fill request and byte address.
REQ-008 Port D_DONE / D_DATA  output  1 / 32  per-word completion pulse and word to the data cache.
REQ-009 Port AV_ADDRESS  output  ADDRBITS  downstream word address, equal to the granted xADDR[31:2].
REQ-010 Port AV_READ / AV_BURSTCOUNT  output  1 / 5  downstream read strobe and burst length (= LINESIZE).
REQ-011 Port AV_WAITREQUEST / AV_READDATA / AV_READDATAVALID  input  1 / 32 / 1  downstream handshake and return data.
REQ-012 Port GRANT  output  2  one-hot owner of the current burst: bit0 instruction, bit1 data; 0 when idle.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE and DATA.
REQ-014 In IDLE, I_REQ and D_REQ SHALL be sampled each cycle; a request seen high SHALL move the FSM to ISSUE the next cycle, with the owner, its address and GRANT latched.
REQ-015 With a single requester high, that requester SHALL be granted.
REQ-016 With both requesters high in the same IDLE cycle, the requester not granted most recently SHALL win (round-robin); after reset the instruction side SHALL win the first tie.
REQ-017 In ISSUE, AV_READ SHALL be 1 with AV_ADDRESS and AV_BURSTCOUNT stable until a cycle with AV_WAITREQUEST=0; in that cycle the FSM SHALL move to DATA, and AV_READ SHALL be 0 from the next cycle.
REQ-018 In DATA, each cycle with AV_READDATAVALID=1 SHALL produce, one cycle later, a one-cycle xDONE=1 on the owner side only, with xDATA equal to that beat's AV_READDATA.
REQ-019 A beat counter of log2(LINESIZE) bits SHALL count returned beats; on the LINESIZE-th beat the FSM SHALL return to IDLE; the counter SHALL wrap to 0.
REQ-020 The earliest next grant SHALL be sampled in the IDLE cycle after the last beat, giving a minimum of one idle cycle between bursts.
REQ-021 A request arriving during another owner's burst SHALL be served only once IDLE is reached; requests are level-held by the caches until their first xDONE.
REQ-022 A request deasserted before it is sampled in IDLE SHALL be ignored without side effects.
REQ-023 AV_READDATAVALID received in IDLE or ISSUE SHALL be discarded and SHALL NOT pulse any xDONE.
REQ-024 The non-owner xDONE SHALL stay 0 for the whole burst; xDATA of the non-owner is don't-care.

Reset
REQ-025 While RESET_N=0, the FSM SHALL be IDLE and the beat counter 0, with AV_READ=0, I_DONE=0, D_DONE=0 and GRANT=0.
REQ-026 After reset, AV_ADDRESS and xDATA SHALL be 0, and the round-robin pointer SHALL be set to "data last served".
REQ-027 Reset asserted mid-burst SHALL abort the burst immediately, and beats arriving after release SHALL be discarded per REQ-023.

Configuration
REQ-028 With macro L1ARB_DCACHE_PRIORITY_EN defined, the data side SHALL win every tie in IDLE and the round-robin pointer SHALL be removed.
REQ-029 Without L1ARB_DCACHE_PRIORITY_EN, arbitration SHALL follow REQ-016.

Verification
REQ-030 I_REQ=1, I_ADDR=0x0000_1000, AV_WAITREQUEST=0, 8 beats 0x11..0x18 -> AV_READ for 1 cycle, AV_ADDRESS=0x400, AV_BURSTCOUNT=8, 8 I_DONE pulses carrying 0x11..0x18, D_DONE always 0, return to IDLE.
REQ-031 I_REQ and D_REQ both asserted in the same cycle, twice in succession -> first grant instruction, second grant data, and a third tie is granted to instruction again (macro undefined).
REQ-032 Same stimulus as REQ-031 with L1ARB_DCACHE_PRIORITY_EN defined -> data granted on every tie.
REQ-033 AV_WAITREQUEST held 1 for 5 cycles -> AV_READ and AV_ADDRESS stable for 6 cycles, with exactly one accepted command.
REQ-034 RESET_N pulsed low after beat 3 of an 8-beat burst, then 5 stray valid beats -> no xDONE pulses, GRANT=0, and the next I_REQ is served normally.
REQ-035 AV_READDATAVALID asserted while in IDLE -> no xDONE pulse and no state change.

Source files
------------

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter
//   Arbitrates instruction-cache and data-cache line-fill requests onto one
//   burst-read master. A burst is issued as one read command of LINESIZE words
//   and every returned beat is forwarded, one cycle later, to the owner cache.
//
// Ports
//   CLK, RESET_N            clock, asynchronous active-low reset
//   I_REQ, I_ADDR           instruction-cache request and byte address
//   I_DONE, I_DATA          per-word completion pulse and word to the I-cache
//   D_REQ, D_ADDR           data-cache request and byte address
//   D_DONE, D_DATA          per-word completion pulse and word to the D-cache
//   AV_ADDRESS              word address of the current burst
//   AV_READ, AV_BURSTCOUNT  read strobe and burst length (LINESIZE)
//   AV_WAITREQUEST          downstream command back-pressure
//   AV_READDATA/VALID       downstream return data
//   GRANT                   one-hot burst owner (bit0 I, bit1 D), 0 when idle
//
// Configuration
//   L1ARB_DCACHE_PRIORITY_EN  when defined, the data side wins every tie and
//                             the round-robin pointer is not built.

module l1_mem_arbiter #(
  parameter int unsigned LINESIZE = 8,
  parameter int unsigned ADDRBITS = 30
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                I_REQ,
  input  logic [31:0]         I_ADDR,
  output logic                I_DONE,
  output logic [31:0]         I_DATA,
  input  logic                D_REQ,
  input  logic [31:0]         D_ADDR,
  output logic                D_DONE,
  output logic [31:0]         D_DATA,
  output logic [ADDRBITS-1:0] AV_ADDRESS,
  output logic                AV_READ,
  output logic [4:0]          AV_BURSTCOUNT,
  input  logic                AV_WAITREQUEST,
  input  logic [31:0]         AV_READDATA,
  input  logic                AV_READDATAVALID,
  output logic [1:0]          GRANT
);

  localparam int unsigned CNTW  = (LINESIZE > 1) ? $clog2(LINESIZE) : 1;
  localparam int unsigned DATAW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNTW-1:0]      beat_q, beat_d;
  logic [1:0]           grant_q, grant_d;
  logic                 av_read_q, av_read_d;
  logic [ADDRBITS-1:0]  av_addr_q, av_addr_d;
  logic                 i_done_q, i_done_d;
  logic                 d_done_q, d_done_d;
  logic [DATAW-1:0]     i_data_q, i_data_d;
  logic [DATAW-1:0]     d_data_q, d_data_d;
  logic                 sel_data;   // data side wins if sampled this IDLE cycle

  // Byte-offset bits never reach the word-addressed bus.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{I_ADDR[1:0], D_ADDR[1:0]};

`ifdef L1ARB_DCACHE_PRIORITY_EN
  // Fixed priority: data side wins whenever it requests.
  always_comb sel_data = D_REQ;
`else
  // Round-robin: last_d_q set means the data side was served most recently.
  logic last_d_q, last_d_d;

  always_comb sel_data = D_REQ & (~I_REQ | ~last_d_q);

  always_comb begin
    last_d_d = last_d_q;
    if ((state_q == ST_IDLE) && (I_REQ | D_REQ)) last_d_d = sel_data;
  end

  // Reset to "data last served" so the first tie goes to the instruction side.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) last_d_q <= 1'b1;
    else          last_d_q <= last_d_d;
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    grant_d   = grant_q;
    av_read_d = av_read_q;
    av_addr_d = av_addr_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_data_d  = i_data_q;
    d_data_d  = d_data_q;

    case (state_q)
      ST_IDLE: begin
        // Beats arriving here are strays and are dropped.
        if (I_REQ | D_REQ) begin
          state_d   = ST_ISSUE;
          grant_d   = sel_data ? 2'b10 : 2'b01;
          av_addr_d = sel_data ? ADDRBITS'(D_ADDR[31:2]) : ADDRBITS'(I_ADDR[31:2]);
          av_read_d = 1'b1;
          beat_d    = '0;
        end
      end

      ST_ISSUE: begin
        // Command held stable until accepted; stray beats are dropped.
        if (!AV_WAITREQUEST) begin
          state_d   = ST_DATA;
          av_read_d = 1'b0;
        end
      end

      ST_DATA: begin
        if (AV_READDATAVALID) begin
          if (grant_q[1]) begin
            d_done_d = 1'b1;
            d_data_d = AV_READDATA;
          end else begin
            i_done_d = 1'b1;
            i_data_d = AV_READDATA;
          end
          beat_d = beat_q + CNTW'(1);
          // Last beat: the counter wraps to zero on its own.
          if (beat_q == CNTW'(LINESIZE - 1)) begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        grant_d   = 2'b00;
        av_read_d = 1'b0;
        beat_d    = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      grant_q   <= 2'b00;
      av_read_q <= 1'b0;
      av_addr_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_data_q  <= '0;
      d_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      grant_q   <= grant_d;
      av_read_q <= av_read_d;
      av_addr_q <= av_addr_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_data_q  <= i_data_d;
      d_data_q  <= d_data_d;
    end
  end

  assign I_DONE        = i_done_q;
  assign I_DATA        = i_data_q;
  assign D_DONE        = d_done_q;
  assign D_DATA        = d_data_q;
  assign AV_ADDRESS    = av_addr_q;
  assign AV_READ       = av_read_q;
  assign AV_BURSTCOUNT = 5'(LINESIZE);
  assign GRANT         = grant_q;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter
//   Self-checking bench for l1_mem_arbiter: reset values, a table of
//   arbitration rounds, hand-written corner sequences (back-pressure, stray
//   beats, reset mid-burst) and randomized rounds scored against a
//   transaction-level arbitration model.

module tb_l1_mem_arbiter;

  localparam int unsigned LINESIZE = 8;
  localparam int unsigned ADDRBITS = 30;

`ifdef L1ARB_DCACHE_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                RESET_N;
  logic                I_REQ, D_REQ;
  logic [31:0]         I_ADDR, D_ADDR;
  logic                I_DONE, D_DONE;
  logic [31:0]         I_DATA, D_DATA;
  logic [ADDRBITS-1:0] AV_ADDRESS;
  logic                AV_READ;
  logic [4:0]          AV_BURSTCOUNT;
  logic                AV_WAITREQUEST;
  logic [31:0]         AV_READDATA;
  logic                AV_READDATAVALID;
  logic [1:0]          GRANT;

  int n_pass  = 0;
  int n_total = 0;
  logic last_d_m;   // model: data side served most recently

  l1_mem_arbiter #(.LINESIZE(LINESIZE), .ADDRBITS(ADDRBITS)) dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .I_REQ            (I_REQ),
    .I_ADDR           (I_ADDR),
    .I_DONE           (I_DONE),
    .I_DATA           (I_DATA),
    .D_REQ            (D_REQ),
    .D_ADDR           (D_ADDR),
    .D_DONE           (D_DONE),
    .D_DATA           (D_DATA),
    .AV_ADDRESS       (AV_ADDRESS),
    .AV_READ          (AV_READ),
    .AV_BURSTCOUNT    (AV_BURSTCOUNT),
    .AV_WAITREQUEST   (AV_WAITREQUEST),
    .AV_READDATA      (AV_READDATA),
    .AV_READDATAVALID (AV_READDATAVALID),
    .GRANT            (GRANT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Arbitration rule: a lone requester wins; a tie goes to the side not
  // served most recently, or always to data when priority mode is built.
  function automatic logic model_pick(input logic ri, input logic rd);
    if (PRIO) return rd;
    if (ri && rd) return ~last_d_m;
    return rd;
  endfunction

  task automatic do_reset();
    RESET_N = 1'b0;
    I_REQ = 1'b0; D_REQ = 1'b0;
    AV_WAITREQUEST = 1'b0; AV_READDATAVALID = 1'b0; AV_READDATA = '0;
    #2;
    chk("rst_grant",   GRANT,   2'b00);
    chk("rst_av_read", AV_READ, 1'b0);
    chk("rst_dones",   {I_DONE, D_DONE}, 2'b00);
    chk("rst_av_addr", AV_ADDRESS, '0);
    chk("rst_data",    {I_DATA, D_DATA}, 64'h0);
    step();
    step();
    RESET_N  = 1'b1;
    last_d_m = 1'b1;
  endtask

  // Act as the downstream slave for one burst already requested by the
  // caches: check the command, back-pressure it for 'waits' cycles, return
  // 'nbeats' beats and check that every beat reaches the expected owner.
  task automatic serve_burst(input logic exp_d, input logic [31:0] exp_byte_addr,
                             input int waits, input int max_gap, input int nbeats,
                             input logic [31:0] data_base, input bit rnd, input bit stray);
    int n;
    int gap;
    logic [31:0] beat;
    n = 0;
    while (AV_READ !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("cmd_issued", AV_READ, 1'b1);
    if (AV_READ !== 1'b1) return;
    chk("grant",      GRANT, exp_d ? 2'b10 : 2'b01);
    chk("av_address", AV_ADDRESS, exp_byte_addr[31:2]);
    chk("burstcount", AV_BURSTCOUNT, LINESIZE);

    n = 0;
    for (int w = 0; w <= waits; w++) begin
      if (AV_READ === 1'b1 && AV_ADDRESS === exp_byte_addr[31:2]) n++;
      AV_WAITREQUEST   = (w < waits);
      AV_READDATAVALID = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      AV_READDATA      = $urandom;
      step();
      chk("issue_no_done", {I_DONE, D_DONE}, 2'b00);
    end
    AV_WAITREQUEST   = 1'b0;
    AV_READDATAVALID = 1'b0;
    chk("cmd_stable_cycles", n, waits + 1);
    chk("read_dropped", AV_READ, 1'b0);

    for (int b = 0; b < nbeats; b++) begin
      gap = $urandom_range(0, max_gap);
      repeat (gap) begin
        step();
        chk("gap_no_done", {I_DONE, D_DONE}, 2'b00);
      end
      beat = rnd ? 32'($urandom) : data_base + 32'(b);
      AV_READDATAVALID = 1'b1;
      AV_READDATA      = beat;
      step();
      AV_READDATAVALID = 1'b0;
      chk("owner_done", exp_d ? D_DONE : I_DONE, 1'b1);
      chk("other_done", exp_d ? I_DONE : D_DONE, 1'b0);
      chk("done_data",  exp_d ? D_DATA : I_DATA, beat);
      chk("no_reissue", AV_READ, 1'b0);
      if (b == 0) begin
        if (exp_d) D_REQ = 1'b0;
        else       I_REQ = 1'b0;
      end
      if (b < nbeats - 1 || nbeats < LINESIZE)
        chk("grant_held", GRANT, exp_d ? 2'b10 : 2'b01);
    end
    if (nbeats == LINESIZE) chk("grant_released", GRANT, 2'b00);
    last_d_m = exp_d;
  endtask

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic        exp_d_rr;
    logic        exp_d_pri;
  } vec_t;

  vec_t tbl [7];

  logic        pend_i, pend_d, win_d;
  logic [31:0] addr_i, addr_d;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_1040, 32'h0000_2000, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_1080, 32'h0000_2040, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_10C0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_3000, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_4000, 32'h0000_5000, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 32'h0000_4100, 32'h0000_5000, 1'b1, 1'b1};

    I_ADDR = '0; D_ADDR = '0;
    do_reset();

    // Single instruction fill, no back-pressure, beats 0x11..0x18.
    I_REQ = 1'b1; I_ADDR = 32'h0000_1000;
    serve_burst(1'b0, 32'h0000_1000, 0, 0, LINESIZE, 32'h11, 1'b0, 1'b0);
    step();
    chk("idle_after_burst_read",  AV_READ, 1'b0);
    chk("idle_after_burst_grant", GRANT, 2'b00);

    // Stray beats while idle.
    for (int k = 0; k < 3; k++) begin
      AV_READDATAVALID = 1'b1; AV_READDATA = 32'hDEAD_0000 + 32'(k);
      step();
      chk("idle_stray_done",  {I_DONE, D_DONE}, 2'b00);
      chk("idle_stray_grant", GRANT, 2'b00);
      chk("idle_stray_read",  AV_READ, 1'b0);
    end
    AV_READDATAVALID = 1'b0;

    // Table of arbitration rounds starting from a fresh pointer.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      I_REQ = tbl[k].ireq; I_ADDR = tbl[k].iaddr;
      D_REQ = tbl[k].dreq; D_ADDR = tbl[k].daddr;
      win_d = PRIO ? tbl[k].exp_d_pri : tbl[k].exp_d_rr;
      serve_burst(win_d, win_d ? tbl[k].daddr : tbl[k].iaddr, k % 3, k % 2,
                  LINESIZE, 32'h100 * 32'(k + 1), 1'b0, 1'b0);
    end
    I_REQ = 1'b0; D_REQ = 1'b0;
    step();

    // Long back-pressure: command held for six cycles, accepted once.
    D_REQ = 1'b1; D_ADDR = 32'h0000_7700;
    serve_burst(1'b1, 32'h0000_7700, 5, 0, LINESIZE, 32'hA0, 1'b0, 1'b1);
    step();

    // Reset in the middle of a burst, then stray beats, then a normal fill.
    I_REQ = 1'b1; I_ADDR = 32'h0000_2200;
    serve_burst(1'b0, 32'h0000_2200, 0, 0, 3, 32'h30, 1'b0, 1'b0);
    RESET_N = 1'b0;
    I_REQ = 1'b0; D_REQ = 1'b0;
    #2;
    chk("abort_grant", GRANT, 2'b00);
    chk("abort_read",  AV_READ, 1'b0);
    chk("abort_dones", {I_DONE, D_DONE}, 2'b00);
    step();
    RESET_N  = 1'b1;
    last_d_m = 1'b1;
    for (int k = 0; k < 5; k++) begin
      AV_READDATAVALID = 1'b1; AV_READDATA = 32'hBAD0_0000 + 32'(k);
      step();
      chk("post_abort_done",  {I_DONE, D_DONE}, 2'b00);
      chk("post_abort_grant", GRANT, 2'b00);
    end
    AV_READDATAVALID = 1'b0;
    I_REQ = 1'b1; I_ADDR = 32'h0000_8000;
    serve_burst(1'b0, 32'h0000_8000, 1, 1, LINESIZE, 32'h50, 1'b0, 1'b0);

    // Randomized rounds; the losing side keeps its request held.
    pend_i = 1'b0; pend_d = 1'b0; addr_i = '0; addr_d = '0;
    for (int r = 0; r < 60; r++) begin
      if (!pend_i && $urandom_range(0, 2) != 0) begin pend_i = 1'b1; addr_i = $urandom; end
      if (!pend_d && $urandom_range(0, 2) != 0) begin pend_d = 1'b1; addr_d = $urandom; end
      if (!pend_i && !pend_d) begin pend_i = 1'b1; addr_i = $urandom; end
      I_REQ = pend_i; I_ADDR = addr_i;
      D_REQ = pend_d; D_ADDR = addr_d;
      win_d = model_pick(pend_i, pend_d);
      serve_burst(win_d, win_d ? addr_d : addr_i, $urandom_range(0, 3), 2,
                  LINESIZE, 32'h0, 1'b1, 1'b1);
      if (win_d) pend_d = 1'b0;
      else       pend_i = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
